glyph_encoder: RTL and testbench

//   Reverse of the 8x16 font lookup: takes a 128-bit monochrome glyph bitmap and returns the 7-bit ASCII code whose glyph matches it.

---
 rtl/glyph_pkg.sv | 17 +
 rtl/char_decoder.sv | 25 ++
 rtl/glyph_encoder.sv | 105 ++++++++++
 tb/tb_glyph_encoder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// Shared constants for the glyph search path: search range, the glyph that
// marks an unpopulated font slot, and the search FSM state encoding.
package glyph_pkg;

    localparam logic [6:0] CODE_FIRST = 7'h20;
    localparam logic [6:0] CODE_LAST  = 7'h7E;
    localparam logic [6:0] CODE_NONE  = 7'h00;

    // Hollow box drawn for codes without a real glyph; never reported as a match.
    localparam logic [127:0] UNDEFINED_GLYPH = 128'h0000_FE82_8282_8282_8282_82FE_0000_0000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_e;

endpackage

// File: rtl/char_decoder.sv
// 8x16 font ROM: 7-bit code in, 128-bit bitmap out (bit 127 = row 0, leftmost
// pixel). Codes without a populated glyph return UNDEFINED_GLYPH.
module char_decoder
    import glyph_pkg::*;
(
    input  logic [6:0]   char,
    output logic [127:0] pixels
);

    // Font lookup, one 16-row glyph per populated code
    always_comb begin
        pixels = UNDEFINED_GLYPH;
        case (char)
            7'h20:   pixels = 128'h0000_0000_0000_0000_0000_0000_0000_0000; // space
            7'h30:   pixels = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000; // 0
            7'h31:   pixels = 128'h0000_1838_7818_1818_1818_187E_0000_0000; // 1
            7'h41:   pixels = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000; // A
            7'h42:   pixels = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000; // B
            7'h43:   pixels = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000; // C
            7'h7A:   pixels = 128'h0000_0000_00FE_CC18_3060_C6FE_0000_0000; // z
            default: pixels = UNDEFINED_GLYPH;
        endcase
    end

endmodule

// File: rtl/glyph_encoder.sv
// Reverse font lookup: latches a 128-bit glyph bitmap and walks the code
// range one candidate per clock against the font ROM, reporting the first
// matching code (or a miss) with a single-cycle done pulse.
module glyph_encoder
    import glyph_pkg::*;
#(
    parameter logic [6:0] FIRST_CODE     = CODE_FIRST,
    parameter logic [6:0] LAST_CODE      = CODE_LAST,
    parameter logic [6:0] NOT_FOUND_CODE = CODE_NONE
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [127:0] pixels,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [6:0]   char
);

    state_e       state_q, state_d;
    logic [6:0]   index_q, index_d;
    logic [127:0] bitmap_q, bitmap_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         found_q, found_d;
    logic [6:0]   char_q, char_d;

    logic [127:0] cand_pixels;
    logic         hit;

    char_decoder u_char_decoder (
        .char   (index_q),
        .pixels (cand_pixels)
    );

    // A candidate counts only if it is a real glyph, so an undefined-box input misses
    assign hit = (bitmap_q == cand_pixels) && (cand_pixels != UNDEFINED_GLYPH);

    // Next-state and output logic for the idle/search FSM
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        bitmap_d = bitmap_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        char_d   = char_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bitmap_d = pixels;
                    index_d  = FIRST_CODE;
                    busy_d   = 1'b1;
                    state_d  = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (hit) begin
                    char_d  = index_q;
                    found_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (index_q == LAST_CODE) begin
                    char_d  = NOT_FOUND_CODE;
                    found_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    index_d = index_q + 7'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset aborts any search without a done pulse
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            index_q  <= FIRST_CODE;
            bitmap_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            char_q   <= 7'h00;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            bitmap_q <= bitmap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            char_q   <= char_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign found = found_q;
    assign char  = char_q;

endmodule

// File: tb/tb_glyph_encoder.sv
// Directed bench for glyph_encoder: edge-accurate latency, result fields,
// start handling while busy / in the done cycle, and asynchronous abort.
module tb_glyph_encoder;

    localparam logic [127:0] G_SPACE = 128'h0;
    localparam logic [127:0] G_ZERO  = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
    localparam logic [127:0] G_A     = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
    localparam logic [127:0] G_B     = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
    localparam logic [127:0] G_C     = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
    localparam logic [127:0] G_LZ    = 128'h0000_0000_00FE_CC18_3060_C6FE_0000_0000;
    localparam logic [127:0] G_UNDEF = 128'h0000_FE82_8282_8282_8282_82FE_0000_0000;
    localparam logic [127:0] G_RAND  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam int BOUND = 200;

    logic         clock;
    logic         resetn;
    logic         start;
    logic [127:0] pixels;
    logic         busy;
    logic         done;
    logic         found;
    logic [6:0]   char;

    int total  = 0;
    int passed = 0;

    glyph_encoder dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .pixels (pixels),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .char   (char)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Count edges until done is seen (sampled 1 time unit after each edge)
    task automatic wait_done(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clock);
            #1;
            n++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end while (done !== 1'b1 && n < BOUND);
    endtask

    // Issue one search, scramble pixels after acceptance, check result and latency
    task automatic search(input string tag, input logic [127:0] bm, input logic [6:0] exp_char,
                          input logic exp_found, input int exp_edges);
        int n;
        bit busy_ok;
        @(negedge clock);
        pixels = bm;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
        pixels = ~bm;
        chk({tag, "_busy_t0"}, busy, 1'b1);
        wait_done(n, busy_ok);
        chk({tag, "_edges"}, n, exp_edges);
        chk({tag, "_char"}, char, exp_char);
        chk({tag, "_found"}, found, exp_found);
        chk({tag, "_busy_during"}, busy_ok, 1'b1);
        chk({tag, "_busy_end"}, busy, 1'b0);
        @(posedge clock);
        #1;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_char_hold"}, char, exp_char);
    endtask

    initial begin : stim
        int  n;
        bit  busy_ok;
        bit  saw_done;

        resetn = 1'b0;
        start  = 1'b0;
        pixels = '0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_char", char, 7'h00);
        @(negedge clock);
        resetn = 1'b1;

        search("space", G_SPACE, 7'h20, 1'b1, 1);
        search("A",     G_A,     7'h41, 1'b1, 34);
        search("z",     G_LZ,    7'h7A, 1'b1, 91);
        search("zero",  G_ZERO,  7'h30, 1'b1, 17);
        search("undef", G_UNDEF, 7'h00, 1'b0, 95);
        search("rand",  G_RAND,  7'h00, 1'b0, 95);

        // start with 'B', a start pulse carrying 'C' arrives mid-search
        @(negedge clock);
        pixels = G_B;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        start  = 1'b1;
        pixels = G_C;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("busy_start_busy", busy, 1'b1);
        wait_done(n, busy_ok);
        chk("busy_start_edges", n + 5, 35);
        chk("busy_start_char", char, 7'h42);
        chk("busy_start_found", found, 1'b1);

        // start in the done cycle is accepted
        start  = 1'b1;
        pixels = G_C;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("done_start_done_drop", done, 1'b0);
        chk("done_start_busy", busy, 1'b1);
        chk("done_start_char_hold", char, 7'h42);
        wait_done(n, busy_ok);
        chk("done_start_edges", n, 36);
        chk("done_start_char", char, 7'h43);
        chk("done_start_found", found, 1'b1);

        // asynchronous abort in the middle of a long search
        @(negedge clock);
        pixels = G_LZ;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_char", char, 7'h00);
        chk("abort_found", found, 1'b0);
        repeat (2) @(negedge clock);
        resetn   = 1'b1;
        saw_done = 1'b0;
        repeat (120) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 1'b0);
        chk("abort_idle_busy", busy, 1'b0);

        search("post_abort_A", G_A, 7'h41, 1'b1, 34);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
